// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round helper functions.
// A state is indexed [row][col]; block byte i maps to row i%4, column i/4.
package aes_pkg;

   localparam int unsigned NR = 10;

   typedef logic [7:0]             byte_t;
   typedef logic [31:0]            word_t;
   typedef logic [127:0]           block_t;
   typedef logic [0:3][0:3][7:0]   state_t;

   localparam logic [1:10][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   function automatic byte_t xtime(input byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column bytes packed MSB-first: {row0, row1, row2, row3}.
   function automatic word_t mix_column(input word_t col);
      byte_t a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic state_t mix_columns(input state_t s);
      state_t o;
      word_t  m;
      for (int c = 0; c < 4; c++) begin
         m       = mix_column({s[0][c], s[1][c], s[2][c], s[3][c]});
         o[0][c] = m[31:24];
         o[1][c] = m[23:16];
         o[2][c] = m[15:8];
         o[3][c] = m[7:0];
      end
      return o;
   endfunction

   function automatic state_t shift_rows(input state_t s);
      state_t o;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[r][c] = s[r][(c + r) % 4];
         end
      end
      return o;
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic state_t to_state(input block_t b);
      state_t s;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            s[r][c] = b[127 - 8 * (4 * c + r) -: 8];
         end
      end
      return s;
   endfunction

   function automatic block_t from_state(input state_t s);
      block_t b;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            b[127 - 8 * (4 * c + r) -: 8] = s[r][c];
         end
      end
      return b;
   endfunction

   function automatic state_t add_round_key(input state_t s, input block_t k);
      return s ^ to_state(k);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a combinational 256-entry lookup.
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout_c
);

   always_comb begin
      dout_c = 8'h00;
      case (din)
         8'h00: dout_c = 8'h63; 8'h01: dout_c = 8'h7c; 8'h02: dout_c = 8'h77; 8'h03: dout_c = 8'h7b; 8'h04: dout_c = 8'hf2; 8'h05: dout_c = 8'h6b; 8'h06: dout_c = 8'h6f; 8'h07: dout_c = 8'hc5;
         8'h08: dout_c = 8'h30; 8'h09: dout_c = 8'h01; 8'h0a: dout_c = 8'h67; 8'h0b: dout_c = 8'h2b; 8'h0c: dout_c = 8'hfe; 8'h0d: dout_c = 8'hd7; 8'h0e: dout_c = 8'hab; 8'h0f: dout_c = 8'h76;
         8'h10: dout_c = 8'hca; 8'h11: dout_c = 8'h82; 8'h12: dout_c = 8'hc9; 8'h13: dout_c = 8'h7d; 8'h14: dout_c = 8'hfa; 8'h15: dout_c = 8'h59; 8'h16: dout_c = 8'h47; 8'h17: dout_c = 8'hf0;
         8'h18: dout_c = 8'had; 8'h19: dout_c = 8'hd4; 8'h1a: dout_c = 8'ha2; 8'h1b: dout_c = 8'haf; 8'h1c: dout_c = 8'h9c; 8'h1d: dout_c = 8'ha4; 8'h1e: dout_c = 8'h72; 8'h1f: dout_c = 8'hc0;
         8'h20: dout_c = 8'hb7; 8'h21: dout_c = 8'hfd; 8'h22: dout_c = 8'h93; 8'h23: dout_c = 8'h26; 8'h24: dout_c = 8'h36; 8'h25: dout_c = 8'h3f; 8'h26: dout_c = 8'hf7; 8'h27: dout_c = 8'hcc;
         8'h28: dout_c = 8'h34; 8'h29: dout_c = 8'ha5; 8'h2a: dout_c = 8'he5; 8'h2b: dout_c = 8'hf1; 8'h2c: dout_c = 8'h71; 8'h2d: dout_c = 8'hd8; 8'h2e: dout_c = 8'h31; 8'h2f: dout_c = 8'h15;
         8'h30: dout_c = 8'h04; 8'h31: dout_c = 8'hc7; 8'h32: dout_c = 8'h23; 8'h33: dout_c = 8'hc3; 8'h34: dout_c = 8'h18; 8'h35: dout_c = 8'h96; 8'h36: dout_c = 8'h05; 8'h37: dout_c = 8'h9a;
         8'h38: dout_c = 8'h07; 8'h39: dout_c = 8'h12; 8'h3a: dout_c = 8'h80; 8'h3b: dout_c = 8'he2; 8'h3c: dout_c = 8'heb; 8'h3d: dout_c = 8'h27; 8'h3e: dout_c = 8'hb2; 8'h3f: dout_c = 8'h75;
         8'h40: dout_c = 8'h09; 8'h41: dout_c = 8'h83; 8'h42: dout_c = 8'h2c; 8'h43: dout_c = 8'h1a; 8'h44: dout_c = 8'h1b; 8'h45: dout_c = 8'h6e; 8'h46: dout_c = 8'h5a; 8'h47: dout_c = 8'ha0;
         8'h48: dout_c = 8'h52; 8'h49: dout_c = 8'h3b; 8'h4a: dout_c = 8'hd6; 8'h4b: dout_c = 8'hb3; 8'h4c: dout_c = 8'h29; 8'h4d: dout_c = 8'he3; 8'h4e: dout_c = 8'h2f; 8'h4f: dout_c = 8'h84;
         8'h50: dout_c = 8'h53; 8'h51: dout_c = 8'hd1; 8'h52: dout_c = 8'h00; 8'h53: dout_c = 8'hed; 8'h54: dout_c = 8'h20; 8'h55: dout_c = 8'hfc; 8'h56: dout_c = 8'hb1; 8'h57: dout_c = 8'h5b;
         8'h58: dout_c = 8'h6a; 8'h59: dout_c = 8'hcb; 8'h5a: dout_c = 8'hbe; 8'h5b: dout_c = 8'h39; 8'h5c: dout_c = 8'h4a; 8'h5d: dout_c = 8'h4c; 8'h5e: dout_c = 8'h58; 8'h5f: dout_c = 8'hcf;
         8'h60: dout_c = 8'hd0; 8'h61: dout_c = 8'hef; 8'h62: dout_c = 8'haa; 8'h63: dout_c = 8'hfb; 8'h64: dout_c = 8'h43; 8'h65: dout_c = 8'h4d; 8'h66: dout_c = 8'h33; 8'h67: dout_c = 8'h85;
         8'h68: dout_c = 8'h45; 8'h69: dout_c = 8'hf9; 8'h6a: dout_c = 8'h02; 8'h6b: dout_c = 8'h7f; 8'h6c: dout_c = 8'h50; 8'h6d: dout_c = 8'h3c; 8'h6e: dout_c = 8'h9f; 8'h6f: dout_c = 8'ha8;
         8'h70: dout_c = 8'h51; 8'h71: dout_c = 8'ha3; 8'h72: dout_c = 8'h40; 8'h73: dout_c = 8'h8f; 8'h74: dout_c = 8'h92; 8'h75: dout_c = 8'h9d; 8'h76: dout_c = 8'h38; 8'h77: dout_c = 8'hf5;
         8'h78: dout_c = 8'hbc; 8'h79: dout_c = 8'hb6; 8'h7a: dout_c = 8'hda; 8'h7b: dout_c = 8'h21; 8'h7c: dout_c = 8'h10; 8'h7d: dout_c = 8'hff; 8'h7e: dout_c = 8'hf3; 8'h7f: dout_c = 8'hd2;
         8'h80: dout_c = 8'hcd; 8'h81: dout_c = 8'h0c; 8'h82: dout_c = 8'h13; 8'h83: dout_c = 8'hec; 8'h84: dout_c = 8'h5f; 8'h85: dout_c = 8'h97; 8'h86: dout_c = 8'h44; 8'h87: dout_c = 8'h17;
         8'h88: dout_c = 8'hc4; 8'h89: dout_c = 8'ha7; 8'h8a: dout_c = 8'h7e; 8'h8b: dout_c = 8'h3d; 8'h8c: dout_c = 8'h64; 8'h8d: dout_c = 8'h5d; 8'h8e: dout_c = 8'h19; 8'h8f: dout_c = 8'h73;
         8'h90: dout_c = 8'h60; 8'h91: dout_c = 8'h81; 8'h92: dout_c = 8'h4f; 8'h93: dout_c = 8'hdc; 8'h94: dout_c = 8'h22; 8'h95: dout_c = 8'h2a; 8'h96: dout_c = 8'h90; 8'h97: dout_c = 8'h88;
         8'h98: dout_c = 8'h46; 8'h99: dout_c = 8'hee; 8'h9a: dout_c = 8'hb8; 8'h9b: dout_c = 8'h14; 8'h9c: dout_c = 8'hde; 8'h9d: dout_c = 8'h5e; 8'h9e: dout_c = 8'h0b; 8'h9f: dout_c = 8'hdb;
         8'ha0: dout_c = 8'he0; 8'ha1: dout_c = 8'h32; 8'ha2: dout_c = 8'h3a; 8'ha3: dout_c = 8'h0a; 8'ha4: dout_c = 8'h49; 8'ha5: dout_c = 8'h06; 8'ha6: dout_c = 8'h24; 8'ha7: dout_c = 8'h5c;
         8'ha8: dout_c = 8'hc2; 8'ha9: dout_c = 8'hd3; 8'haa: dout_c = 8'hac; 8'hab: dout_c = 8'h62; 8'hac: dout_c = 8'h91; 8'had: dout_c = 8'h95; 8'hae: dout_c = 8'he4; 8'haf: dout_c = 8'h79;
         8'hb0: dout_c = 8'he7; 8'hb1: dout_c = 8'hc8; 8'hb2: dout_c = 8'h37; 8'hb3: dout_c = 8'h6d; 8'hb4: dout_c = 8'h8d; 8'hb5: dout_c = 8'hd5; 8'hb6: dout_c = 8'h4e; 8'hb7: dout_c = 8'ha9;
         8'hb8: dout_c = 8'h6c; 8'hb9: dout_c = 8'h56; 8'hba: dout_c = 8'hf4; 8'hbb: dout_c = 8'hea; 8'hbc: dout_c = 8'h65; 8'hbd: dout_c = 8'h7a; 8'hbe: dout_c = 8'hae; 8'hbf: dout_c = 8'h08;
         8'hc0: dout_c = 8'hba; 8'hc1: dout_c = 8'h78; 8'hc2: dout_c = 8'h25; 8'hc3: dout_c = 8'h2e; 8'hc4: dout_c = 8'h1c; 8'hc5: dout_c = 8'ha6; 8'hc6: dout_c = 8'hb4; 8'hc7: dout_c = 8'hc6;
         8'hc8: dout_c = 8'he8; 8'hc9: dout_c = 8'hdd; 8'hca: dout_c = 8'h74; 8'hcb: dout_c = 8'h1f; 8'hcc: dout_c = 8'h4b; 8'hcd: dout_c = 8'hbd; 8'hce: dout_c = 8'h8b; 8'hcf: dout_c = 8'h8a;
         8'hd0: dout_c = 8'h70; 8'hd1: dout_c = 8'h3e; 8'hd2: dout_c = 8'hb5; 8'hd3: dout_c = 8'h66; 8'hd4: dout_c = 8'h48; 8'hd5: dout_c = 8'h03; 8'hd6: dout_c = 8'hf6; 8'hd7: dout_c = 8'h0e;
         8'hd8: dout_c = 8'h61; 8'hd9: dout_c = 8'h35; 8'hda: dout_c = 8'h57; 8'hdb: dout_c = 8'hb9; 8'hdc: dout_c = 8'h86; 8'hdd: dout_c = 8'hc1; 8'hde: dout_c = 8'h1d; 8'hdf: dout_c = 8'h9e;
         8'he0: dout_c = 8'he1; 8'he1: dout_c = 8'hf8; 8'he2: dout_c = 8'h98; 8'he3: dout_c = 8'h11; 8'he4: dout_c = 8'h69; 8'he5: dout_c = 8'hd9; 8'he6: dout_c = 8'h8e; 8'he7: dout_c = 8'h94;
         8'he8: dout_c = 8'h9b; 8'he9: dout_c = 8'h1e; 8'hea: dout_c = 8'h87; 8'heb: dout_c = 8'he9; 8'hec: dout_c = 8'hce; 8'hed: dout_c = 8'h55; 8'hee: dout_c = 8'h28; 8'hef: dout_c = 8'hdf;
         8'hf0: dout_c = 8'h8c; 8'hf1: dout_c = 8'ha1; 8'hf2: dout_c = 8'h89; 8'hf3: dout_c = 8'h0d; 8'hf4: dout_c = 8'hbf; 8'hf5: dout_c = 8'he6; 8'hf6: dout_c = 8'h42; 8'hf7: dout_c = 8'h68;
         8'hf8: dout_c = 8'h41; 8'hf9: dout_c = 8'h99; 8'hfa: dout_c = 8'h2d; 8'hfb: dout_c = 8'h0f; 8'hfc: dout_c = 8'hb0; 8'hfd: dout_c = 8'h54; 8'hfe: dout_c = 8'hbb; 8'hff: dout_c = 8'h16;
      endcase
   end

endmodule

// File: rtl/aes_cipher.sv
// Fully unrolled AES-128 encryptor: ten combinational rounds with on-the-fly
// key expansion, result captured in a single output register.
module aes_cipher
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] datain,
   input  logic [127:0] key,
   output logic [127:0] dataout
);

   block_t dataout_d;
   block_t dataout_q;

   for (genvar n = 1; n <= NR; n++) begin : g_rnd
      block_t rk_prev;
      block_t rk;
      state_t st_prev;
      state_t st_sub;
      state_t st_mix;
      state_t st;
      word_t  rot;
      word_t  sub_word;
      word_t  temp;
      word_t  k0;
      word_t  k1;
      word_t  k2;
      word_t  k3;

      // Round 0 AddRoundKey is folded into the first round's input.
      if (n == 1) begin : g_src
         assign rk_prev = key;
         assign st_prev = to_state(datain ^ key);
      end else begin : g_src
         assign rk_prev = g_rnd[n-1].rk;
         assign st_prev = g_rnd[n-1].st;
      end

      assign rot = rot_word(rk_prev[31:0]);

      for (genvar b = 0; b < 4; b++) begin : g_ks_sbox
         aes_sbox u_sbox (
            .din    (rot[31 - 8 * b -: 8]),
            .dout_c (sub_word[31 - 8 * b -: 8])
         );
      end

      // Each new word written out flat to keep the chain free of self-loops.
      assign temp = sub_word ^ {RCON[n], 24'h000000};
      assign k0   = rk_prev[127:96] ^ temp;
      assign k1   = rk_prev[95:64]  ^ k0;
      assign k2   = rk_prev[63:32]  ^ k1;
      assign k3   = rk_prev[31:0]   ^ k2;
      assign rk   = {k0, k1, k2, k3};

      for (genvar r = 0; r < 4; r++) begin : g_row
         for (genvar c = 0; c < 4; c++) begin : g_col
            aes_sbox u_sbox (
               .din    (st_prev[r][c]),
               .dout_c (st_sub[r][c])
            );
         end
      end

      if (n < NR) begin : g_mix
         assign st_mix = mix_columns(shift_rows(st_sub));
      end else begin : g_mix
         assign st_mix = shift_rows(st_sub);
      end

      assign st = add_round_key(st_mix, rk);
   end

   always_comb begin
      dataout_d = from_state(g_rnd[NR].st);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dataout_q <= '0;
      end else begin
         dataout_q <= dataout_d;
      end
   end

   assign dataout = dataout_q;

endmodule

// File: tb/tb_aes_cipher.sv
// Directed bench for aes_cipher: FIPS-197 vectors, reset behaviour and
// streaming against an independent byte-array AES model with a computed S-box.
module tb_aes_cipher;

   logic         clk;
   logic         rst;
   logic [127:0] datain;
   logic [127:0] key;
   logic [127:0] dataout;

   int n_cmp;
   int n_err;

   logic [7:0] sbox_tab [256];

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes_cipher dut (
      .clk     (clk),
      .rst     (rst),
      .datain  (datain),
      .key     (key),
      .dataout (dataout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
      logic [15:0] d;
      d = {x, x} << k;
      return d[15:8];
   endfunction

   // S-box from GF(2^8) inverse plus affine transform.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++) begin
            if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         end
         sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model_aes(input logic [127:0] k, input logic [127:0] p);
      logic [7:0]   s  [16];
      logic [7:0]   rk [16];
      logic [7:0]   t  [16];
      logic [7:0]   tw [4];
      logic [7:0]   a  [4];
      logic [7:0]   rc;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) begin
         rk[i] = k[127 - 8 * i -: 8];
         s[i]  = p[127 - 8 * i -: 8] ^ rk[i];
      end
      rc = 8'h01;
      for (int rnd = 1; rnd <= 10; rnd++) begin
         tw[0] = sbox_tab[rk[13]] ^ rc;
         tw[1] = sbox_tab[rk[14]];
         tw[2] = sbox_tab[rk[15]];
         tw[3] = sbox_tab[rk[12]];
         for (int i = 0; i < 4; i++) rk[i] = rk[i] ^ tw[i];
         for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
         rc = gmul(rc, 8'h02);
         for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[4 * c + r] = t[4 * ((c + r) % 4) + r];
         if (rnd != 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int r = 0; r < 4; r++) a[r] = s[4 * c + r];
               s[4*c+0] = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
               s[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
               s[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
               s[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
      end
      for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; key = KEY_B; datain = PT_B;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (dataout !== 128'h0) begin
            n_err++;
            $display("FAIL reset_hold[%0d]: got %h want %h", i, dataout, 128'h0);
         end
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (dataout !== CT_B) begin
         n_err++;
         $display("FAIL reset_release: got %h want %h", dataout, CT_B);
      end
   endtask

   task automatic test_vectors();
      key = KEY_B; datain = PT_B;
      tick();
      n_cmp++;
      if (dataout !== CT_B) begin
         n_err++;
         $display("FAIL fips_app_b: got %h want %h", dataout, CT_B);
      end
      key = KEY_C; datain = PT_C;
      tick();
      n_cmp++;
      if (dataout !== CT_C) begin
         n_err++;
         $display("FAIL fips_app_c1: got %h want %h", dataout, CT_C);
      end
      key = 128'h0; datain = 128'h0;
      tick();
      n_cmp++;
      if (dataout !== CT_Z) begin
         n_err++;
         $display("FAIL all_zero: got %h want %h", dataout, CT_Z);
      end
   endtask

   task automatic test_stream_fixed_key();
      logic [127:0] pt;
      logic [127:0] exp;
      key = 128'h11111111222222223333333344444444;
      for (int i = 0; i < 8; i++) begin
         pt     = 128'h10101010202020203030303040404040 + 128'(i);
         datain = pt;
         exp    = model_aes(key, pt);
         tick();
         n_cmp++;
         if (dataout !== exp) begin
            n_err++;
            $display("FAIL stream_fixed[%0d]: got %h want %h", i, dataout, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] exp;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            key = KEY_B; datain = PT_B; exp = CT_B;
         end else begin
            key = KEY_C; datain = PT_C; exp = CT_C;
         end
         rst = (i == 4);
         if (i == 4) exp = 128'h0;
         tick();
         n_cmp++;
         if (dataout !== exp) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: got %h want %h", i, dataout, exp);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      rst    = 1'b1;
      key    = '0;
      datain = '0;
      build_sbox();
      test_reset();
      test_vectors();
      test_stream_fixed_key();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aes_cipher.md
# aes_cipher

Fully unrolled AES-128 encryption core (FIPS-197) that turns one 128-bit plaintext block and one 128-bit key into one ciphertext block. All ten rounds and the on-the-fly key expansion are combinational. The result is captured in a single output register. The block sits in the crypto datapath as a one-cycle-latency, one-block-per-cycle encryptor with no handshake.

## Interface
- No parameters; key size fixed at 128 bits, Nr = 10.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- datain  in  128  plaintext block; byte 0 = datain[127:120].
- key  in  128  cipher key, same byte order; may change every cycle.
- dataout  out  128  registered ciphertext, same byte order.

## Operation
- State mapping: byte i of a block goes to state[r][c] with r = i mod 4 and c = i div 4 (column-major, FIPS-197 §3.4).
- Round 0: AddRoundKey(key).
- Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey(rk[n]).
- Round 10: SubBytes, ShiftRows, AddRoundKey(rk[10]); no MixColumns.
- Key expansion is combinational and derived from the current key, never from stored state:
  - w[0..3] = key words.
  - For i ≥ 4, w[i] = w[i-4] ^ (i mod 4 == 0 ? SubWord(RotWord(w[i-1])) ^ Rcon[i/4] : w[i-1]).
  - Rcon = 01,02,04,08,10,20,40,80,1b,36 in the top byte.
- MixColumns works in GF(2^8) with polynomial 0x11b. xtime(b) = (b<<1) ^ (b[7] ? 0x1b : 0).
- Register update on each rising clk:
  - rst = 1: dataout <= 0.
  - Otherwise: dataout <= AES-128(key, datain).
- No enable, no valid, no decrypt path. Every cycle is treated as a new block.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on dataout right after edge N.
- Throughput: 1 block per cycle. Inputs may change every cycle with no idle cycles.
- Reset value: dataout = 128'h0.
- Reset asserted mid-stream: the next edge forces dataout to 0 and discards that cycle's result. The first edge after rst falls produces the ciphertext of the inputs present at that edge.
- Key and data changing on the same cycle is the normal case. The output must always reflect the key/data pair sampled at that edge; no stale round keys.
- Single-cycle combinational depth (10 rounds) sets fmax. No internal pipelining is allowed, because the latency is fixed at 1.

## Structure
- Package aes_pkg holds:
  - typedefs: byte_t, word_t, block_t [127:0], state_t [4][4] of byte_t;
  - constants: NR = 10 and the RCON array;
  - functions: xtime, mix_column, shift_rows, rot_word, and block↔state conversion.
- Sub-module aes_sbox: 8-bit in, 8-bit out, combinational forward S-box as a 256-entry case table.
  - 16 instances per round for SubBytes.
  - 4 instances per expansion step for SubWord.
- The top level (aes_cipher) generates the round and key-schedule chains and holds the output register.

## Test plan
- Reset: assert rst for 2 cycles with arbitrary inputs -> dataout = 0 on both cycles. Deassert -> next edge gives the correct ciphertext.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> dataout 3925841d02dc09fbdc118597196a0b32 one cycle later.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Streaming, fixed key: key 11111111222222223333333344444444, pt starting at 10101010202020203030303040404040 and incrementing by 1 every cycle. Expect a new output every cycle, each matching the software model of the pt from the previous edge.
- Streaming, varying key: alternate the App. B and App. C.1 key/pt pairs on consecutive cycles -> outputs alternate 3925841d… / 69c4e0d8… with 1-cycle latency. Assert rst on one cycle mid-stream -> that cycle outputs 0 and the stream resumes correctly afterwards.
